// File: rtl/serdes_align_pkg.sv
// Shared types and default constants for the SERDES word aligner.
package serdes_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE,
    ST_ALIGNED,
    ST_FAIL
  } lane_state_e;

  localparam int         DEF_WIDTH         = 10;
  localparam int         DEF_CHANNELS      = 4;
  localparam logic [9:0] DEF_TRAIN_PATTERN = 10'h3E0;
  localparam int         DEF_MATCH_COUNT   = 4;
  localparam int         DEF_SLIP_GAP      = 8;
  localparam int         DEF_LOCK_WAIT     = 255;

  // Bits needed for a counter that must be able to hold maxVal.
  function automatic int cntWidth(input int maxVal);
    if (maxVal < 1) return 1;
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/serdes_align_lane.sv
// One lane of the word aligner: waits for DPA lock, hunts for the training
// word by pulsing bitslip, then forwards aligned data.
module serdes_align_lane
  import serdes_align_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN[WIDTH-1:0],
  parameter int               MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int               SLIP_GAP      = DEF_SLIP_GAP,
  parameter int               LOCK_WAIT     = DEF_LOCK_WAIT
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             trainReq_i,
  input  logic             dpaLock_i,
  input  logic             dataValid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bitslip_o,
  output logic [WIDTH-1:0] data_o,
  output logic             dataValid_o,
  output logic             aligned_o,
  output logic             alignErr_o
);

  localparam int                  WAIT_W      = cntWidth(LOCK_WAIT);
  localparam logic [WAIT_W-1:0]   WAIT_MAX    = WAIT_W'(LOCK_WAIT);
  localparam int                  MATCH_W     = cntWidth(MATCH_COUNT);
  localparam logic [MATCH_W-1:0]  MATCH_MAX   = MATCH_W'(MATCH_COUNT);
  localparam int                  SLIP_W      = cntWidth(WIDTH);
  localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(WIDTH);
  localparam int                  SETTLE_W    = cntWidth(SLIP_GAP);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SLIP_GAP > 0) ? SLIP_GAP - 1 : 0);

  lane_state_e         state_q, state_d;
  logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [MATCH_W-1:0]  matchCnt_q, matchCnt_d;
  logic [SLIP_W-1:0]   slipCnt_q, slipCnt_d;
  logic [SETTLE_W-1:0] settleCnt_q, settleCnt_d;
  logic                bitslip_q, dataValid_q, aligned_q, alignErr_q;
  logic [WIDTH-1:0]    data_q;
  logic                capture;

  // Next-state and counter logic; restart requests override every state and
  // all counters saturate instead of wrapping.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    matchCnt_d  = matchCnt_q;
    slipCnt_d   = slipCnt_q;
    settleCnt_d = settleCnt_q;
    if (trainReq_i || !enable_i) begin
      state_d     = ST_IDLE;
      waitCnt_d   = '0;
      matchCnt_d  = '0;
      slipCnt_d   = '0;
      settleCnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          waitCnt_d   = '0;
          matchCnt_d  = '0;
          slipCnt_d   = '0;
          settleCnt_d = '0;
          if (dpaLock_i) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (!dpaLock_i) state_d = ST_IDLE;
          else if (waitCnt_q == WAIT_MAX) state_d = ST_CHECK;
          else waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
        ST_CHECK: begin
          if (dataValid_i) begin
            if (data_i == TRAIN_PATTERN) begin
              matchCnt_d = (matchCnt_q == MATCH_MAX) ? matchCnt_q : matchCnt_q + MATCH_W'(1);
              if (matchCnt_d == MATCH_MAX) state_d = ST_ALIGNED;
            end else begin
              matchCnt_d = '0;
              state_d    = (slipCnt_q == SLIP_MAX) ? ST_FAIL : ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          slipCnt_d   = (slipCnt_q == SLIP_MAX) ? slipCnt_q : slipCnt_q + SLIP_W'(1);
          settleCnt_d = '0;
          state_d     = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settleCnt_q == SETTLE_LAST) state_d = ST_CHECK;
          else settleCnt_d = settleCnt_q + SETTLE_W'(1);
        end
        ST_ALIGNED: begin
          if (!dpaLock_i) state_d = ST_IDLE;
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign capture = (state_q == ST_ALIGNED) && (state_d == ST_ALIGNED) && dataValid_i;

  // State, counters and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      waitCnt_q   <= '0;
      matchCnt_q  <= '0;
      slipCnt_q   <= '0;
      settleCnt_q <= '0;
      bitslip_q   <= 1'b0;
      dataValid_q <= 1'b0;
      aligned_q   <= 1'b0;
      alignErr_q  <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      matchCnt_q  <= matchCnt_d;
      slipCnt_q   <= slipCnt_d;
      settleCnt_q <= settleCnt_d;
      bitslip_q   <= (state_d == ST_SLIP);
      aligned_q   <= (state_d == ST_ALIGNED);
      alignErr_q  <= (state_d == ST_FAIL);
      dataValid_q <= capture;
      if (capture) data_q <= data_i;
    end
  end

  assign bitslip_o   = bitslip_q;
  assign data_o      = data_q;
  assign dataValid_o = dataValid_q;
  assign aligned_o   = aligned_q;
  assign alignErr_o  = alignErr_q;

endmodule

// File: rtl/serdes_word_aligner.sv
// Multi-lane word aligner top: slices the lane buses and reports overall readiness.
module serdes_word_aligner
  import serdes_align_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter int               CHANNELS      = DEF_CHANNELS,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN[WIDTH-1:0],
  parameter int               MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int               SLIP_GAP      = DEF_SLIP_GAP,
  parameter int               LOCK_WAIT     = DEF_LOCK_WAIT
) (
  input  logic                      fabric_clk_div,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      train_req,
  input  logic [CHANNELS-1:0]       dpa_lock,
  input  logic [CHANNELS-1:0]       data_valid,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       bitslip_adj,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic [CHANNELS-1:0]       data_out_valid,
  output logic [CHANNELS-1:0]       aligned,
  output logic [CHANNELS-1:0]       align_err,
  output logic                      ready
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    serdes_align_lane #(
      .WIDTH         (WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_COUNT   (MATCH_COUNT),
      .SLIP_GAP      (SLIP_GAP),
      .LOCK_WAIT     (LOCK_WAIT)
    ) u_lane (
      .clock_i     (fabric_clk_div),
      .reset_i     (reset),
      .enable_i    (enable),
      .trainReq_i  (train_req),
      .dpaLock_i   (dpa_lock[c]),
      .dataValid_i (data_valid[c]),
      .data_i      (data_in[c*WIDTH +: WIDTH]),
      .bitslip_o   (bitslip_adj[c]),
      .data_o      (data_out[c*WIDTH +: WIDTH]),
      .dataValid_o (data_out_valid[c]),
      .aligned_o   (aligned[c]),
      .alignErr_o  (align_err[c])
    );
  end

  assign ready = &aligned;

endmodule

// File: tb/tb_serdes_word_aligner.sv
// Self-checking bench for serdes_word_aligner with a behavioural SERDES lane model.
module tb_serdes_word_aligner;

  localparam int         W       = 10;
  localparam int         CH      = 2;
  localparam logic [9:0] PAT     = 10'h3E0;
  localparam int         MATCHES = 4;
  localparam int         GAP     = 8;
  localparam int         LOCKW   = 16;

  localparam int MODE_PAT    = 0;
  localparam int MODE_ZERO   = 1;
  localparam int MODE_MANUAL = 2;

  logic            fabric_clk_div = 1'b0;
  logic            reset, enable, train_req;
  logic [CH-1:0]   dpa_lock, data_valid;
  logic [CH*W-1:0] data_in;
  logic [CH-1:0]   bitslip_adj, data_out_valid, aligned, align_err;
  logic [CH*W-1:0] data_out;
  logic            ready;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int rot       [CH];
  int mode      [CH];
  int pulses    [CH];
  int minGap    [CH];
  int lastPulse [CH];
  int runFault  [CH];
  int alignRise [CH];
  logic [CH-1:0] prevSlip    = '0;
  logic [CH-1:0] prevAligned = '0;

  serdes_word_aligner #(
    .WIDTH         (W),
    .CHANNELS      (CH),
    .TRAIN_PATTERN (PAT),
    .MATCH_COUNT   (MATCHES),
    .SLIP_GAP      (GAP),
    .LOCK_WAIT     (LOCKW)
  ) dut (
    .fabric_clk_div (fabric_clk_div),
    .reset          (reset),
    .enable         (enable),
    .train_req      (train_req),
    .dpa_lock       (dpa_lock),
    .data_valid     (data_valid),
    .data_in        (data_in),
    .bitslip_adj    (bitslip_adj),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .aligned        (aligned),
    .align_err      (align_err),
    .ready          (ready)
  );

  always #5 fabric_clk_div = ~fabric_clk_div;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    logic [2*W-1:0] t;
    t = {v, v} << n;
    return t[2*W-1:W];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearStats();
    cycle = 0;
    for (int c = 0; c < CH; c++) begin
      pulses[c]    = 0;
      minGap[c]    = 1000000;
      lastPulse[c] = -1;
      runFault[c]  = 0;
      alignRise[c] = -1;
    end
  endtask

  // Drive each lane as a SERDES would, advance one cycle, then observe bitslip
  // pulses (each pulse rotates the modelled lane one step toward alignment).
  task automatic applyStimulus();
    for (int c = 0; c < CH; c++) begin
      if (mode[c] == MODE_PAT) data_in[c*W +: W] = rotl(PAT, rot[c]);
      else if (mode[c] == MODE_ZERO) data_in[c*W +: W] = '0;
    end
    @(negedge fabric_clk_div);
    cycle++;
    for (int c = 0; c < CH; c++) begin
      if (bitslip_adj[c]) begin
        pulses[c]++;
        if (prevSlip[c]) runFault[c]++;
        if (lastPulse[c] >= 0 && (cycle - lastPulse[c]) < minGap[c]) minGap[c] = cycle - lastPulse[c];
        lastPulse[c] = cycle;
        rot[c] = (rot[c] + W - 1) % W;
      end
      if (aligned[c] && !prevAligned[c] && alignRise[c] < 0) alignRise[c] = cycle;
    end
    prevSlip    = bitslip_adj;
    prevAligned = aligned;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_bitslip"}, 32'(bitslip_adj), 32'd0);
    checkOutput({tag, "_dvalid"}, 32'(data_out_valid), 32'd0);
    checkOutput({tag, "_aligned"}, 32'(aligned), 32'd0);
    checkOutput({tag, "_err"}, 32'(align_err), 32'd0);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
    checkOutput({tag, "_dout"}, 32'(data_out), 32'd0);
  endtask

  task automatic runUntilAligned(input logic [CH-1:0] mask, input int budget, input string tag);
    int n;
    n = 0;
    while (((aligned & mask) != mask) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, 32'((aligned & mask) == mask), 32'd1);
  endtask

  task automatic runUntilErr(input logic [CH-1:0] mask, input int budget, input string tag);
    int n;
    n = 0;
    while (((align_err & mask) != mask) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, 32'((align_err & mask) == mask), 32'd1);
  endtask

  initial begin
    logic [W-1:0]  word;
    logic [W-1:0]  expData [CH];
    logic [CH-1:0] haveData;
    logic [CH-1:0] vld;
    int            offA, offB, n;

    reset = 1'b1; enable = 1'b0; train_req = 1'b0;
    dpa_lock = '0; data_valid = '0; data_in = '0;
    for (int c = 0; c < CH; c++) begin
      rot[c]  = 0;
      mode[c] = MODE_PAT;
    end
    clearStats();
    @(negedge fabric_clk_div);
    repeat (3) applyStimulus();
    checkResetValues("reset");

    // Lane 0 already aligned, lane 1 rotated by three.
    reset = 1'b0; enable = 1'b1; data_valid = '1;
    rot[1] = 3;
    clearStats();
    dpa_lock = '1;
    runUntilAligned(2'b11, 150, "align_both_timeout");
    checkOutput("lane0_align_cycle_ok", 32'(alignRise[0] >= LOCKW + MATCHES && alignRise[0] <= 22), 32'd1);
    checkOutput("lane0_pulses", 32'(pulses[0]), 32'd0);
    checkOutput("lane1_pulses", 32'(pulses[1]), 32'd3);
    checkOutput("lane1_single_cycle", 32'(runFault[1]), 32'd0);
    checkOutput("lane1_gap_ok", 32'(minGap[1] >= GAP + 1), 32'd1);
    checkOutput("ready_after_align", 32'(ready), 32'd1);
    checkOutput("no_err_after_align", 32'(align_err), 32'd0);

    // Random data and valid while aligned: data_out follows the last valid word.
    haveData = '0;
    for (int c = 0; c < CH; c++) begin
      mode[c]    = MODE_MANUAL;
      expData[c] = '0;
    end
    for (int i = 0; i < 40; i++) begin
      vld = 2'($urandom);
      data_valid = vld;
      for (int c = 0; c < CH; c++) begin
        word = W'($urandom);
        data_in[c*W +: W] = word;
        if (vld[c]) expData[c] = word;
      end
      applyStimulus();
      haveData = haveData | vld;
      for (int c = 0; c < CH; c++) begin
        checkOutput("sb_dvalid", 32'(data_out_valid[c]), 32'(vld[c]));
        checkOutput("sb_aligned", 32'(aligned[c]), 32'd1);
        if (haveData[c]) checkOutput("sb_dout", 32'(data_out[c*W +: W]), 32'(expData[c]));
      end
    end

    // Single valid word on lane 0, then loss of lock.
    data_valid = 2'b01;
    data_in[0 +: W] = 10'h155;
    applyStimulus();
    checkOutput("d155_dout", 32'(data_out[0 +: W]), 32'h155);
    checkOutput("d155_dvalid", 32'(data_out_valid[0]), 32'd1);
    data_valid = '0;
    data_in[0 +: W] = 10'h2AA;
    applyStimulus();
    checkOutput("hold_dvalid", 32'(data_out_valid[0]), 32'd0);
    checkOutput("hold_dout", 32'(data_out[0 +: W]), 32'h155);
    dpa_lock[0] = 1'b0;
    applyStimulus();
    checkOutput("lockloss_aligned", 32'(aligned[0]), 32'd0);
    checkOutput("lockloss_ready", 32'(ready), 32'd0);
    checkOutput("lockloss_lane1", 32'(aligned[1]), 32'd1);

    // Lane 0 never sees the pattern and must give up after WIDTH slips.
    data_valid = '1;
    mode[0] = MODE_ZERO; mode[1] = MODE_PAT; rot[1] = 0;
    train_req = 1'b1;
    applyStimulus();
    train_req = 1'b0;
    checkOutput("train_clears_aligned", 32'(aligned), 32'd0);
    dpa_lock = '1;
    clearStats();
    runUntilErr(2'b01, 300, "fail_timeout");
    checkOutput("fail_pulses", 32'(pulses[0]), 32'd10);
    checkOutput("fail_single_cycle", 32'(runFault[0]), 32'd0);
    checkOutput("fail_aligned", 32'(aligned[0]), 32'd0);
    checkOutput("fail_ready", 32'(ready), 32'd0);
    repeat (20) applyStimulus();
    checkOutput("fail_hold_err", 32'(align_err[0]), 32'd1);
    checkOutput("fail_hold_pulses", 32'(pulses[0]), 32'd10);
    checkOutput("fail_lane1_aligned", 32'(aligned[1]), 32'd1);
    checkOutput("fail_lane1_err", 32'(align_err[1]), 32'd0);

    // train_req out of FAIL, then realign both lanes from random offsets.
    offA = $urandom_range(1, 9);
    offB = $urandom_range(0, 9);
    mode[0] = MODE_PAT; rot[0] = offA; rot[1] = offB;
    train_req = 1'b1;
    applyStimulus();
    train_req = 1'b0;
    checkOutput("train_err_cleared", 32'(align_err), 32'd0);
    checkOutput("train_bitslip_low", 32'(bitslip_adj), 32'd0);
    clearStats();
    runUntilAligned(2'b11, 400, "realign_timeout");
    checkOutput("realign_pulses0", 32'(pulses[0]), 32'(offA));
    checkOutput("realign_pulses1", 32'(pulses[1]), 32'(offB));
    checkOutput("realign_from_idle", 32'(alignRise[0] >= LOCKW + MATCHES), 32'd1);
    checkOutput("realign_gap0", 32'(minGap[0] >= GAP + 1), 32'd1);
    checkOutput("realign_ready", 32'(ready), 32'd1);

    // Reset together with train_req while lane 1 is mid-slip.
    rot[1] = 5;
    train_req = 1'b1;
    applyStimulus();
    train_req = 1'b0;
    n = 0;
    while (!bitslip_adj[1] && n < 100) begin
      applyStimulus();
      n++;
    end
    checkOutput("slip_seen", 32'(bitslip_adj[1]), 32'd1);
    reset = 1'b1;
    train_req = 1'b1;
    applyStimulus();
    checkResetValues("reset_train");
    reset = 1'b0;
    train_req = 1'b0;
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serdes_word_aligner.md
SERDES_WORD_ALIGNER -- requirements
Module: serdes_word_aligner

Interface
REQ-001 Parameter WIDTH, default 10, deserialization width per channel; legal range 3-10.
REQ-002 Parameter CHANNELS, default 4, number of independent lanes; legal range 1-8.
REQ-003 Parameter TRAIN_PATTERN, default 10'h3E0 (WIDTH bits), training word searched for on every lane.
REQ-004 Parameter MATCH_COUNT, default 4, consecutive matching valid words required to declare alignment.
REQ-005 Parameter SLIP_GAP, default 8, settle cycles after each bitslip pulse before checking resumes.
REQ-006 Parameter LOCK_WAIT, default 255, cycles DPA lock must hold before training starts.
REQ-007 Port fabric_clk_div, in, 1: the only clock; all logic rises on it.
REQ-008 Port reset, in, 1: synchronous, active-high reset.
REQ-009 Port enable, in, 1: global active-high enable.
REQ-010 Port train_req, in, 1: restarts alignment on all lanes.
REQ-011 Ports dpa_lock and data_valid, in, CHANNELS each: per-lane I_SERDES DPA_LOCK and DATA_VALID.
REQ-012 Port data_in, in, CHANNELS*WIDTH: per-lane I_SERDES Q; lane c occupies bits [c*WIDTH +: WIDTH].
REQ-013 Port bitslip_adj, out, CHANNELS: per-lane pulse to I_SERDES BITSLIP_ADJ.
REQ-014 Port data_out, out, CHANNELS*WIDTH: aligned, registered lane data.
REQ-015 Ports data_out_valid, aligned and align_err, out, CHANNELS each: per-lane status.
REQ-016 Port ready, out, 1: AND of all aligned bits.

Function
REQ-017 Each lane SHALL run an independent FSM with states IDLE, WAIT_LOCK, CHECK, SLIP, SETTLE, ALIGNED, FAIL.
REQ-018 Transitions out of IDLE and WAIT_LOCK:
- IDLE -> WAIT_LOCK when enable=1 and dpa_lock[c]=1; the wait counter is cleared on entry.
- WAIT_LOCK -> IDLE if dpa_lock[c] falls.
- WAIT_LOCK -> CHECK when the counter reaches LOCK_WAIT.
REQ-019 In CHECK, on data_valid[c]=1 with a matching word, the match counter SHALL increment; reaching MATCH_COUNT goes to ALIGNED. Non-valid cycles leave the counters unchanged.
REQ-020 In CHECK, on data_valid[c]=1 with a mismatching word:
- the match counter clears;
- the lane goes to FAIL if the slip counter equals WIDTH;
- otherwise the lane goes to SLIP.
REQ-021 SLIP and SETTLE:
- SLIP lasts exactly one cycle, drives bitslip_adj[c]=1 and increments the slip counter.
- SETTLE holds for SLIP_GAP cycles, then returns to CHECK.
- bitslip_adj[c] SHALL be 0 in every other state.
REQ-022 ALIGNED:
- aligned[c]=1.
- On data_valid[c]=1, data_out lane c takes data_in lane c and data_out_valid[c] pulses one cycle later (1-cycle latency).
- data_out holds its last value otherwise.
REQ-023 Leaving ALIGNED: when dpa_lock[c] falls, the lane goes to IDLE, with aligned[c] and data_out_valid[c] low from the next cycle.
REQ-024 FAIL: align_err[c]=1, and the lane holds until train_req or reset.
REQ-025 Priority, highest first: reset, then train_req (any state -> IDLE, counters cleared, align_err cleared next cycle), then enable=0 (any state -> IDLE), then normal transitions.
REQ-026 The counters SHALL be sized with $clog2 and SHALL saturate rather than wrap.

Reset
REQ-027 On reset, every lane SHALL enter IDLE and all counters SHALL clear.
REQ-028 On reset, bitslip_adj, data_out_valid, aligned, align_err and ready SHALL be 0, and data_out SHALL be 0.
REQ-029 A reset asserted mid-slip SHALL take bitslip_adj low on the next edge.

Structure
REQ-030 Package serdes_align_pkg SHALL hold the FSM state enum and the default constants (width, pattern, counts).
REQ-031 Per-lane logic SHALL live in sub-module serdes_align_lane, instantiated CHANNELS times by generate; the top holds only slicing and the ready AND.

Verification
Configuration: WIDTH=10, CHANNELS=2, TRAIN_PATTERN=10'h3E0, MATCH_COUNT=4, SLIP_GAP=8, LOCK_WAIT=16; data_valid is high every cycle unless stated.
REQ-032 Lane 0 already aligned: dpa_lock[0] rises at cycle 0 -> aligned[0]=1 by cycle 22, and bitslip_adj[0] never pulses.
REQ-033 Lane 1 rotated by 3 (the bench model rotates on each pulse) -> exactly 3 single-cycle bitslip_adj[1] pulses, at least 9 cycles apart, then aligned[1]=1 and ready=1.
REQ-034 Lane 0 fed a constant 10'h000 -> 10 pulses, then align_err[0]=1, aligned[0]=0 and ready=0.
REQ-035 Lane 0 aligned, then data_in=10'h155 with valid for one cycle -> data_out lane 0 = 10'h155 with data_out_valid[0]=1 exactly one cycle later; dropping dpa_lock[0] then gives aligned[0]=0 next cycle.
REQ-036 train_req=1 while lane 0 is in FAIL -> align_err[0]=0 next cycle and the lane restarts from IDLE; reset and train_req together -> all outputs match the reset values.
